// File: rtl/wisc_mem_pkg.sv
// Shared types and default constants for the block-burst memory responder.
// Imported by the responder top and its storage array.
package wisc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam int DEF_LATENCY     = 4;
    localparam int DEF_BLOCK_WORDS = 8;
    localparam int DEF_DEPTH_WORDS = 32768;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;

endpackage

// File: rtl/mem_array_1r1w.sv
// Word storage: synchronous write, combinational read, no reset so
// contents survive a responder reset.
module mem_array_1r1w
    import wisc_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH_WORDS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/memory_responder.sv
// Single-word writes and critical-word-first block read bursts with a
// fixed latency from acceptance to the first response word.
module memory_responder
    import wisc_mem_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_last
);

    localparam int IW     = $clog2(BLOCK_WORDS);
    localparam int BASE_W = 15 - IW;
    localparam int AW     = $clog2(DEPTH_WORDS);

    // LATENCY==1 never uses the wait state, so its wrapped value is harmless
    localparam logic [3:0]    WAIT_END = 4'(LATENCY - 2);
    localparam logic [IW-1:0] CNT_END  = IW'(BLOCK_WORDS - 1);

    state_e              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       cnt_q, cnt_d;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [AW-1:0]       mem_raddr;
    logic [15:0]         mem_rdata;
    logic                unused_addr0;

    assign unused_addr0 = req_addr[0];
    assign mem_waddr    = AW'(req_addr[15:1]);
    assign mem_raddr    = AW'({base_q, idx_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        base_d    = base_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_wr) begin
                        mem_we = 1'b1;
                    end else begin
                        base_d  = req_addr[15:IW+1];
                        idx_d   = req_addr[IW:1];
                        cnt_d   = '0;
                        wait_d  = '0;
                        state_d = (LATENCY == 1) ? ST_BURST : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == WAIT_END) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                rsp_valid = 1'b1;
                // index wraps inside the block; base never moves
                idx_d     = idx_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_END) begin
                    rsp_last = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rsp_data = '0;
        rsp_addr = '0;
        if (rsp_valid) begin
            rsp_data = mem_rdata;
            rsp_addr = {base_q, idx_q, 1'b0};
        end
    end

    mem_array_1r1w #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (req_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: a LATENCY=4 and a LATENCY=1 instance checked
// every cycle against a transaction-level model, plus literal pins.
module tb_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [2];
    logic        req_wr    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_data  [2];
    logic [15:0] rsp_addr  [2];
    logic        rsp_last  [2];

    memory_responder #(.LATENCY(4), .BLOCK_WORDS(8), .DEPTH_WORDS(32768)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .rsp_addr(rsp_addr[0]),
        .rsp_last(rsp_last[0])
    );

    memory_responder #(.LATENCY(1), .BLOCK_WORDS(8), .DEPTH_WORDS(32768)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .rsp_addr(rsp_addr[1]),
        .rsp_last(rsp_last[1])
    );

    int npass = 0;
    int nchk  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic int lat_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [34:0] obs(int i);
        return {req_ready[i], rsp_valid[i], rsp_last[i], rsp_addr[i], rsp_data[i]};
    endfunction

    // Model: a read accepted at edge n occupies intervals n .. n+LAT+6;
    // its words appear in intervals n+LAT-1 .. n+LAT+6.
    int          cyc = 0;
    int          acc [2] = '{-1000, -1000};
    int          acc_any [2] = '{-1, -1};
    logic [15:0] bbase [2];
    int          crit [2];
    logic [15:0] mmem [2][32768];
    bit          chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) acc[i] <= -1000;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cyc > acc[i] + lat_of(i) + 6 && req_valid[i]) begin
                    acc_any[i] <= cyc + 1;
                    if (req_wr[i]) begin
                        mmem[i][req_addr[i][15:1]] <= req_wdata[i];
                    end else begin
                        acc[i]   <= cyc + 1;
                        bbase[i] <= req_addr[i] & 16'hFFF0;
                        crit[i]  <= int'(req_addr[i][3:1]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int k;
                logic ev, el, er;
                logic [15:0] ea, ed;
                k  = cyc - (acc[i] + lat_of(i) - 1);
                ev = (k >= 0 && k < 8);
                el = (k == 7);
                er = (cyc > acc[i] + lat_of(i) + 6);
                ea = 16'h0;
                ed = 16'h0;
                if (ev) begin
                    ea = bbase[i] + 16'(((crit[i] + k) % 8) * 2);
                    ed = mmem[i][ea[15:1]];
                end
                if (rst_n)
                    chk($sformatf("cyc%0d_dut%0d", cyc, i), obs(i), {er, ev, el, ea, ed});
                else
                    chk($sformatf("cyc%0d_dut%0d_rst", cyc, i), obs(i) & 35'h3FFFFFFFF,
                        {1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
            end
        end
    end

    task automatic issue(input int i, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input bit hold, output int n);
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        n = -1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (acc_any[i] == cyc) begin
                n = cyc;
                break;
            end
        end
        if (!hold) req_valid[i] = 1'b0;
        if (n < 0) begin
            nchk++;
            $display("FAIL issue_timeout dut%0d: request at %0h never accepted", i, a);
        end
    endtask

    // Called in the interval of the acceptance edge.
    task automatic lit_burst(input int i, input int lat, input logic [15:0] ea [8],
                             input bit pin_en, input logic [15:0] pin_a,
                             input logic [15:0] pin_d, input string tag);
        for (int c = 0; c < lat - 1; c++) begin
            chk($sformatf("%s_wait%0d", tag, c), {req_ready[i], rsp_valid[i]}, 2'b00);
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_w%0d", tag, k), {rsp_valid[i], rsp_last[i], rsp_addr[i]},
                {1'b1, (k == 7) ? 1'b1 : 1'b0, ea[k]});
            if (pin_en && ea[k] == pin_a)
                chk($sformatf("%s_data", tag), rsp_data[i], pin_d);
            @(negedge clk);
        end
        chk($sformatf("%s_done", tag), {req_ready[i], rsp_valid[i]}, 2'b10);
    endtask

    initial begin
        int n, n1, n2, nr, nw;
        logic [15:0] ea [8];

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_addr[i]  = 16'h0;
            req_wdata[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_state_dut%0d", i), obs(i), {1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
        chk_en = 1'b1;

        for (int w = 0; w < 256; w++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'b1;
                req_wr[i]    = 1'b1;
                req_addr[i]  = 16'(w * 2);
                req_wdata[i] = 16'($urandom);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) req_valid[i] = 1'b0;

        issue(0, 1'b1, 16'h0024, 16'hBEEF, 1'b0, n);
        issue(0, 1'b1, 16'h0100, 16'h5A5A, 1'b0, n);

        issue(0, 1'b0, 16'h0020, 16'h0, 1'b0, n);
        ea = '{16'h20, 16'h22, 16'h24, 16'h26, 16'h28, 16'h2A, 16'h2C, 16'h2E};
        lit_burst(0, 4, ea, 1'b1, 16'h0024, 16'hBEEF, "blk20");

        issue(0, 1'b0, 16'h003A, 16'h0, 1'b0, n);
        ea = '{16'h3A, 16'h3C, 16'h3E, 16'h30, 16'h32, 16'h34, 16'h36, 16'h38};
        lit_burst(0, 4, ea, 1'b0, 16'h0, 16'h0, "wrap3A");

        issue(0, 1'b0, 16'h0100, 16'h0, 1'b1, nr);
        req_wr[0]    = 1'b1;
        req_wdata[0] = 16'h1234;
        ea = '{16'h100, 16'h102, 16'h104, 16'h106, 16'h108, 16'h10A, 16'h10C, 16'h10E};
        lit_burst(0, 4, ea, 1'b1, 16'h0100, 16'h5A5A, "busywr");
        issue(0, 1'b1, 16'h0100, 16'h1234, 1'b0, nw);
        chk("busywr_delay", 64'(nw - nr), 64'd12);
        issue(0, 1'b0, 16'h0100, 16'h0, 1'b0, n);
        lit_burst(0, 4, ea, 1'b1, 16'h0100, 16'h1234, "afterwr");

        issue(0, 1'b0, 16'h0040, 16'h0, 1'b0, n);
        repeat (5) @(negedge clk);
        chk("rst_pre_word3", {rsp_valid[0], rsp_addr[0]}, {1'b1, 16'h0044});
        #2 rst_n = 1'b0;
        #1 chk("rst_abort", {rsp_valid[0], rsp_last[0], rsp_addr[0], rsp_data[0]}, 34'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {req_ready[0], rsp_valid[0]}, 2'b10);
        issue(0, 1'b0, 16'h0020, 16'h0, 1'b0, n);
        ea = '{16'h20, 16'h22, 16'h24, 16'h26, 16'h28, 16'h2A, 16'h2C, 16'h2E};
        lit_burst(0, 4, ea, 1'b1, 16'h0024, 16'hBEEF, "rst_keep");

        issue(1, 1'b0, 16'h0000, 16'h0, 1'b0, n);
        ea = '{16'h00, 16'h02, 16'h04, 16'h06, 16'h08, 16'h0A, 16'h0C, 16'h0E};
        lit_burst(1, 1, ea, 1'b0, 16'h0, 16'h0, "lat1");

        for (int i = 0; i < 2; i++) begin
            issue(i, 1'b0, 16'h0000, 16'h0, 1'b1, n1);
            req_addr[i] = 16'h0010;
            issue(i, 1'b0, 16'h0010, 16'h0, 1'b0, n2);
            chk($sformatf("b2b_spacing_dut%0d", i), 64'(n2 - n1), (i == 0) ? 64'd12 : 64'd9);
            repeat (14) @(negedge clk);
        end

        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                req_wr[i]    = ($urandom_range(0, 2) == 0);
                req_addr[i]  = 16'($urandom_range(0, 511));
                req_wdata[i] = 16'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) req_valid[i] = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
